// File: rtl/pid_terms_pkg.sv
// Shared types and constants for the PID error-term producer.
package pid_terms_pkg;

    localparam int ERR_W_DEF   = 10;
    localparam int INTEG_W_DEF = 18;
    localparam int D_DEPTH_DEF = 4;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [INTEG_W_DEF-1:0] INTEG_MAX =
        {1'b0, {(INTEG_W_DEF-1){1'b1}}};
    localparam logic [INTEG_W_DEF-1:0] INTEG_MIN =
        {1'b1, {(INTEG_W_DEF-1){1'b0}}};

endpackage

// File: rtl/err_delay_q.sv
// Error sample delay line: oldest-entry tap plus a flag that marks
// the shift completing the initial fill.
module err_delay_q
    import pid_terms_pkg::*;
#(
    parameter int ERR_W   = ERR_W_DEF,
    parameter int D_DEPTH = D_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift,
    input  logic signed [ERR_W-1:0] din,
    output logic signed [ERR_W-1:0] oldest,
    output logic                    fill_done
);

    localparam int CNT_W = $clog2(D_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(D_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_DEPTH - 1);

    logic signed [ERR_W-1:0] q [D_DEPTH];
    logic [CNT_W-1:0]        cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D_DEPTH; i++) begin
                q[i] <= '0;
            end
            cnt <= '0;
        end else if (shift) begin
            q[0] <= din;
            for (int i = 1; i < D_DEPTH; i++) begin
                q[i] <= q[i-1];
            end
            if (cnt != CNT_FULL) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign oldest    = q[D_DEPTH-1];
    // High only on the shift that brings the queue to D_DEPTH samples
    assign fill_done = shift && (cnt == CNT_LAST);

endmodule

// File: rtl/pid_err_terms.sv
// Integral and derivative raw terms from saturated error samples.
// Define PID_TERMS_INTEG_SAT_EN to saturate the integrator on overflow.
module pid_err_terms
    import pid_terms_pkg::*;
#(
    parameter int ERR_W   = ERR_W_DEF,
    parameter int INTEG_W = INTEG_W_DEF,
    parameter int D_DEPTH = D_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      err_vld,
    input  logic signed [ERR_W-1:0]   err_sat,
    input  logic                      moving,
    input  logic                      clr_integ,
    output logic signed [INTEG_W-1:0] integ,
    output logic signed [ERR_W:0]     d_diff,
    output logic                      terms_vld,
    output logic                      warm
);

`ifdef PID_TERMS_INTEG_SAT_EN
    localparam logic [INTEG_W-1:0] SAT_MAX = {1'b0, {(INTEG_W-1){1'b1}}};
    localparam logic [INTEG_W-1:0] SAT_MIN = {1'b1, {(INTEG_W-1){1'b0}}};
`endif

    state_t state;
    state_t state_nxt;

    logic signed [ERR_W-1:0]   oldest;
    logic                      fill_done;
    logic signed [INTEG_W-1:0] err_ext;
    logic signed [INTEG_W-1:0] sum;
    logic signed [INTEG_W-1:0] integ_nxt;
    logic signed [ERR_W:0]     diff;
    logic signed [ERR_W:0]     d_nxt;
    logic                      ovf;

    err_delay_q #(
        .ERR_W   (ERR_W),
        .D_DEPTH (D_DEPTH)
    ) u_dq (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift     (err_vld),
        .din       (err_sat),
        .oldest    (oldest),
        .fill_done (fill_done)
    );

    assign err_ext = {{(INTEG_W-ERR_W){err_sat[ERR_W-1]}}, err_sat};
    assign sum     = integ + err_ext;
    // Same-sign operands with a flipped result sign means wrap-around
    assign ovf     = (integ[INTEG_W-1] == err_ext[INTEG_W-1]) &&
                     (sum[INTEG_W-1] != integ[INTEG_W-1]);
    assign diff    = {err_sat[ERR_W-1], err_sat} -
                     {oldest[ERR_W-1], oldest};

    always_comb begin
        integ_nxt = integ;
        if (clr_integ) begin
            integ_nxt = '0;
        end else if (err_vld && moving) begin
            if (!ovf) begin
                integ_nxt = sum;
            end
`ifdef PID_TERMS_INTEG_SAT_EN
            else begin
                integ_nxt = err_ext[INTEG_W-1] ? SAT_MIN : SAT_MAX;
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        d_nxt     = d_diff;
        unique case (state)
            FILL: begin
                if (err_vld) begin
                    d_nxt = '0;
                end
                if (fill_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (err_vld) begin
                    d_nxt = diff;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            integ     <= '0;
            d_diff    <= '0;
            terms_vld <= 1'b0;
        end else begin
            state     <= state_nxt;
            integ     <= integ_nxt;
            d_diff    <= d_nxt;
            terms_vld <= err_vld;
        end
    end

    assign warm = (state == RUN);

endmodule
